// File: rtl/alu_arbiter.sv
// alu_arbiter: two valid/ready requesters share one alu_dp; results return tagged with the requester id.
// Optional build macro ALU_ARBITER_ILLEGAL_OP_EN adds rsp_err and zeroes result/flags for opcodes 5-7.

module alu_dp (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic [3:0]  flags
);
    always_comb begin
        r = '0;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = '0;
        endcase
        flags = {a > b, a < b, a == b, a != b};
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; the granted requester sees ready
// EXEC  | operands registered, ALU result captured at the next edge
// RESP  | response held on rsp_* until the consumer takes it
module alu_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_r,
    output logic [3:0]       rsp_flags,
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    output logic             rsp_err,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arbStateT;

    arbStateT    state;
    logic        lastGrant;
    logic        grantId;
    logic        anyValid;
    logic        accept;
    logic [2:0]  opReg;
    logic [31:0] aReg;
    logic [31:0] bReg;
    logic        idReg;
    logic [31:0] aluR;
    logic [3:0]  aluFlags;

    alu_dp uAlu (
        .op    (opReg),
        .a     (aReg),
        .b     (bReg),
        .r     (aluR),
        .flags (aluFlags)
    );

    assign anyValid = req0_valid | req1_valid;

    always_comb begin
        grantId = req1_valid;
        if (req0_valid && req1_valid)
            grantId = (PRIO_MODE == 1) ? 1'b0 : ~lastGrant;
    end

    // Gated by rst_n so neither requester sees ready while reset is held.
    assign accept     = rst_n && (state == IDLE) && anyValid;
    assign req0_ready = accept && !grantId;
    assign req1_ready = accept && grantId;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            opReg     <= '0;
            aReg      <= '0;
            bReg      <= '0;
            idReg     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_flags <= '0;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
            rsp_err   <= 1'b0;
`endif
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        opReg     <= grantId ? req1_op : req0_op;
                        aReg      <= grantId ? req1_a  : req0_a;
                        bReg      <= grantId ? req1_b  : req0_b;
                        idReg     <= grantId;
                        lastGrant <= grantId;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_r     <= aluR;
                    rsp_flags <= aluFlags;
                    rsp_id    <= idReg;
                    rsp_valid <= 1'b1;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
                    rsp_err   <= (opReg > 3'd4);
                    if (opReg > 3'd4)
                        rsp_flags <= '0;
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand-written corner sequences and random traffic
// checked against a cycle-level behavioural model of the arbiter.

module tb_alu_arbiter;
    localparam int CNT_W = 16;
    localparam int PRIO  = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]       req0_op, req1_op;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0]      rsp_r;
    logic [3:0]       rsp_flags;
    logic [CNT_W-1:0] done_cnt;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    logic             rsp_err;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_MODE(PRIO), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_r      (rsp_r),
        .rsp_flags  (rsp_flags),
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
        .rsp_err    (rsp_err),
`endif
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = waiting, 1 = computing, 2 = response offered.
    int               mPhase;
    bit               mLast;
    logic [CNT_W-1:0] mCnt;
    logic [31:0]      mR, pA, pB;
    logic [3:0]       mF;
    logic [2:0]       pOp;
    bit               mId, pId;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    bit               mErr;
`endif
    int               lastAcc;

    function automatic void modelReset();
        mPhase = 0; mLast = 1'b1; mCnt = '0; mR = '0; mF = '0; mId = 1'b0;
        pOp = '0; pA = '0; pB = '0; pId = 1'b0;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
        mErr = 1'b0;
`endif
    endfunction

    function automatic void refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] f);
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = 32'd0;
        endcase
        f[0] = (a != b);
        f[1] = (a == b);
        f[2] = (a < b);
        f[3] = (a > b);
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
        if (op > 3'd4) f = 4'd0;
`endif
    endfunction

    function automatic bit pickWinner();
        if (req0_valid && !req1_valid) return 1'b0;
        if (req1_valid && !req0_valid) return 1'b1;
        if (PRIO == 1) return 1'b0;
        return !mLast;
    endfunction

    // Called at a negedge with inputs already driven; checks outputs, advances over one posedge.
    task automatic step();
        bit win, any;
        #1;
        any = req0_valid || req1_valid;
        win = pickWinner();
        check("req0_ready", req0_ready, rst_n && mPhase == 0 && any && !win);
        check("req1_ready", req1_ready, rst_n && mPhase == 0 && any && win);
        check("rsp_valid", rsp_valid, mPhase == 2);
        check("busy", busy, mPhase != 0);
        check("done_cnt", done_cnt, mCnt);
        check("rsp_r", rsp_r, mR);
        check("rsp_flags", rsp_flags, mF);
        check("rsp_id", rsp_id, mId);
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
        check("rsp_err", rsp_err, mErr);
`endif
        lastAcc = -1;
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else if (mPhase == 0) begin
            if (any) begin
                pId = win;
                pOp = win ? req1_op : req0_op;
                pA  = win ? req1_a  : req0_a;
                pB  = win ? req1_b  : req0_b;
                mLast = win;
                lastAcc = int'(win);
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            refAlu(pOp, pA, pB, mR, mF);
            mId = pId;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
            mErr = (pOp > 3'd4);
`endif
            mPhase = 2;
        end else if (rsp_ready) begin
            mCnt = mCnt + CNT_W'(1);
            mPhase = 0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) step();
    endtask

    typedef struct {
        bit          who;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expR;
        logic [3:0]  expF;
    } vecT;

    vecT vecs[8];
    int  grants[$];

    initial begin
        logic [3:0]       ef;
        logic [CNT_W-1:0] cntBefore;

        vecs[0] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 4'b1001};
        vecs[1] = '{1'b1, 3'd1, 32'h5,         32'h7,         32'hFFFF_FFFE, 4'b0101};
        vecs[2] = '{1'b0, 3'd4, 32'hF0,        32'hFF,        32'h0000_000F, 4'b0101};
        vecs[3] = '{1'b1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 4'b1001};
        vecs[4] = '{1'b0, 3'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b1001};
        vecs[5] = '{1'b1, 3'd6, 32'h3,         32'h3,         32'h0000_0000, 4'b0010};
        vecs[6] = '{1'b0, 3'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0101};
        vecs[7] = '{1'b1, 3'd0, 32'h7,         32'h7,         32'h0000_000E, 4'b0010};

        rst_n = 1'b0; rsp_ready = 1'b0; lastAcc = -1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
        step();

        // Vector table, one operation at a time with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b);
            rsp_ready = 1'b1;
            step();
            check("tbl_grant", 64'(lastAcc), 64'(vecs[i].who));
            req0_valid = 1'b0; req1_valid = 1'b0;
            step();
            ef = vecs[i].expF;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
            if (vecs[i].op > 3'd4) ef = 4'd0;
            check("tbl_rsp_err", rsp_err, vecs[i].op > 3'd4);
`endif
            check("tbl_rsp_valid", rsp_valid, 1'b1);
            check("tbl_rsp_r", rsp_r, vecs[i].expR);
            check("tbl_rsp_flags", rsp_flags, ef);
            check("tbl_rsp_id", rsp_id, vecs[i].who);
            step();
            check("tbl_done_cnt", done_cnt, 64'(i + 1));
        end

        // Continuous contention: round-robin must alternate starting with req0
        drive(1'b0, 3'd1, 32'h5, 32'h7);
        drive(1'b1, 3'd4, 32'hF0, 32'hFF);
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (lastAcc >= 0) grants.push_back(lastAcc);
            if (rsp_valid) begin
                check("rr_rsp_r", rsp_r, rsp_id ? 32'h0000_000F : 32'hFFFF_FFFE);
                check("rr_rsp_flags", rsp_flags, 4'b0101);
            end
        end
        check("rr_grant_count", 64'(grants.size() >= 4), 64'd1);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check("rr_grant_order", 64'(grants[k]), 64'(k % 2));
        drain();

        // Consumer stalls for 10 cycles in RESP
        drive(1'b0, 3'd0, 32'h1, 32'h2);
        rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        drive(1'b1, 3'd2, 32'hAAAA_5555, 32'hFFFF_0000);
        cntBefore = mCnt;
        for (int c = 0; c < 10; c++) begin
            step();
            check("stall_r", rsp_r, 32'h3);
            check("stall_flags", rsp_flags, 4'b0101);
            check("stall_id", rsp_id, 1'b0);
            check("stall_ready1", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        check("stall_done_cnt", done_cnt, cntBefore + CNT_W'(1));
        check("stall_valid_drop", rsp_valid, 1'b0);
        step();
        check("stall_next_grant", 64'(lastAcc), 64'd1);
        drain();

        // Reset while in EXEC
        drive(1'b0, 3'd0, 32'd10, 32'd20);
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_exec_valid", rsp_valid, 1'b0);
        check("rst_exec_busy", busy, 1'b0);
        check("rst_exec_cnt", done_cnt, 0);
        step();

        // Reset while in RESP, then a normal transaction
        drive(1'b1, 3'd2, 32'hFF, 32'h0F);
        rsp_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        step();
        check("rst_resp_pre_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_resp_valid", rsp_valid, 1'b0);
        check("rst_resp_busy", busy, 1'b0);
        check("rst_resp_r", rsp_r, 32'h0);
        drive(1'b0, 3'd6, 32'h3, 32'h3);
        rsp_ready = 1'b1;
        step();
        check("post_rst_grant", 64'(lastAcc), 64'd0);
        req0_valid = 1'b0;
        step();
        check("post_rst_r", rsp_r, 32'h0);
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
        check("post_rst_flags", rsp_flags, 4'b0000);
        check("post_rst_err", rsp_err, 1'b1);
`else
        check("post_rst_flags", rsp_flags, 4'b0010);
`endif
        step();
        check("post_rst_cnt", done_cnt, 1);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            if (!req0_valid || lastAcc == 0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 3'($urandom_range(0, 7));
                req0_a = $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            end
            if (!req1_valid || lastAcc == 1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 3'($urandom_range(0, 7));
                req1_a = $urandom;
                req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
